// File: rtl/hmmm_pkg.sv
// hmmm_pkg: shared definitions for the HMMM-style multicycle controller.
//   - opcode_e : 4-bit opcode encoding (values 10..15 are undefined)
//   - state_e  : controller FSM states
//   - pcSel / wdSel select constants
//   - instruction field bit positions
package hmmm_pkg;

  typedef enum logic [3:0] {
    OP_HALT   = 4'd0,
    OP_NOP    = 4'd1,
    OP_SETN   = 4'd2,
    OP_ADD    = 4'd3,
    OP_SUB    = 4'd4,
    OP_LOADR  = 4'd5,
    OP_STORER = 4'd6,
    OP_JUMPN  = 4'd7,
    OP_JEQZN  = 4'd8,
    OP_JNEZN  = 4'd9
  } opcode_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  localparam logic       PCSEL_INC  = 1'b0;
  localparam logic       PCSEL_JUMP = 1'b1;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_IMM  = 2'b01;
  localparam logic [1:0] WD_DMEM = 2'b10;

  // Instruction field positions within the 10-bit IR
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RX_MSB  = 5;
  localparam int RX_LSB  = 4;
  localparam int RY_MSB  = 3;
  localparam int RY_LSB  = 2;
  localparam int RZ_MSB  = 1;
  localparam int RZ_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int TGT_MSB = 5;

endpackage

// File: rtl/hmmm_decoder.sv
// hmmm_decoder: purely combinational instruction field decoder.
// Ports:
//   i_instr       in  10 : current IR contents
//   o_opcode      out  4 : decoded opcode (OP_HALT when illegal)
//   o_illegal     out  1 : opcode is 10..15
//   o_ra1         out  2 : rX for jeqzn/jnezn, else rY
//   o_ra2         out  2 : rX for storer, else rZ
//   o_wa3         out  2 : rX
//   o_jump_target out  8 : zero-extended tgt6 for jumpn, imm4 otherwise
//   o_alu_sub     out  1 : high for sub
module hmmm_decoder
  import hmmm_pkg::*;
(
  input  logic [9:0] i_instr,
  output opcode_e    o_opcode,
  output logic       o_illegal,
  output logic [1:0] o_ra1,
  output logic [1:0] o_ra2,
  output logic [1:0] o_wa3,
  output logic [7:0] o_jump_target,
  output logic       o_alu_sub
);

  logic [3:0] w_opc;
  logic [1:0] w_rx;
  logic [1:0] w_ry;
  logic [1:0] w_rz;
  logic [3:0] w_imm;
  logic [5:0] w_tgt;

  assign w_opc = i_instr[OPC_MSB:OPC_LSB];
  assign w_rx  = i_instr[RX_MSB:RX_LSB];
  assign w_ry  = i_instr[RY_MSB:RY_LSB];
  assign w_rz  = i_instr[RZ_MSB:RZ_LSB];
  assign w_imm = i_instr[IMM_MSB:0];
  assign w_tgt = i_instr[TGT_MSB:0];

  assign o_illegal = (w_opc > OP_LAST_LEGAL);
  // Undefined encodings are folded onto OP_HALT; the FSM uses o_illegal
  // to tell the two apart.
  assign o_opcode  = o_illegal ? OP_HALT : opcode_e'(w_opc);

  // Conditional branches test rX, so it goes out on the read port that
  // feeds the zero flag.
  assign o_ra1 = ((o_opcode == OP_JEQZN) || (o_opcode == OP_JNEZN)) ? w_rx : w_ry;
  // storer reads the data to be written from rX on the second port.
  assign o_ra2 = (o_opcode == OP_STORER) ? w_rx : w_rz;
  assign o_wa3 = w_rx;

  assign o_jump_target = (o_opcode == OP_JUMPN) ? {2'b00, w_tgt} : {4'b0000, w_imm};
  assign o_alu_sub     = (o_opcode == OP_SUB);

endmodule

// File: rtl/hmmm_controller.sv
// hmmm_controller: multicycle control FSM for the 4-bit HMMM-style core.
// Sequences FETCH / DECODE / EXECUTE / MEM for each instruction in the IR
// and drives the datapath strobes combinationally from the current state.
// Ports:
//   clk        in   1 : clock, rising edge
//   reset      in   1 : asynchronous active-low reset
//   run        in   1 : start level, only looked at in IDLE
//   instr      in  10 : IR contents
//   zero       in   1 : datapath flag rd1 == 0
//   dmemAck    in   1 : data memory completes the access this cycle
//   imemRead   out  1 : instruction memory read strobe
//   irWrite    out  1 : IR load enable
//   pcWrite    out  1 : PC load enable
//   pcSel      out  1 : 0 = PC+1, 1 = jumpTarget
//   jumpTarget out  8 : branch target
//   ra1/ra2/wa3 out 2 : regfile addresses
//   regWrite   out  1 : regfile write enable
//   aluSub     out  1 : ALU subtract control
//   wdSel      out  2 : write data select (ALU / imm4 / dmem)
//   dmemReq    out  1 : data memory request, held until dmemAck
//   dmemWe     out  1 : store qualifier for dmemReq
//   halted     out  1 : core stopped
//   illegal    out  1 : stopped on an undefined opcode
//   instrCount out  8 : retired-instruction counter (wraps)
module hmmm_controller
  import hmmm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [9:0] instr,
  input  logic       zero,
  input  logic       dmemAck,
  output logic       imemRead,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSel,
  output logic [7:0] jumpTarget,
  output logic [1:0] ra1,
  output logic [1:0] ra2,
  output logic [1:0] wa3,
  output logic       regWrite,
  output logic       aluSub,
  output logic [1:0] wdSel,
  output logic       dmemReq,
  output logic       dmemWe,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] instrCount
);

  state_e     r_state;
  state_e     w_next_state;
  logic [7:0] r_count;
  logic       r_illegal;
  logic       w_retire;

  opcode_e    w_opcode;
  logic       w_illegal;
  logic [1:0] w_ra1;
  logic [1:0] w_ra2;
  logic [1:0] w_wa3;
  logic [7:0] w_jump_target;
  logic       w_alu_sub;

  hmmm_decoder u_decoder (
    .i_instr       (instr),
    .o_opcode      (w_opcode),
    .o_illegal     (w_illegal),
    .o_ra1         (w_ra1),
    .o_ra2         (w_ra2),
    .o_wa3         (w_wa3),
    .o_jump_target (w_jump_target),
    .o_alu_sub     (w_alu_sub)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= 8'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_count <= r_count + 8'd1;
      end
      if ((r_state == ST_DECODE) && w_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    imemRead     = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    pcSel        = PCSEL_INC;
    regWrite     = 1'b0;
    wdSel        = WD_ALU;
    dmemReq      = 1'b0;
    dmemWe       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_next_state = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // IR captures the instruction while PC advances to PC+1
        imemRead     = 1'b1;
        irWrite      = 1'b1;
        pcWrite      = 1'b1;
        w_next_state = ST_DECODE;
      end

      ST_DECODE: begin
        if (w_illegal) begin
          w_next_state = ST_HALT;
        end else begin
          case (w_opcode)
            OP_HALT: w_next_state = ST_HALT;
            OP_NOP: begin
              w_next_state = ST_FETCH;
              w_retire     = 1'b1;
            end
            OP_LOADR, OP_STORER: w_next_state = ST_MEM;
            default: w_next_state = ST_EXECUTE;
          endcase
        end
      end

      ST_EXECUTE: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
        case (w_opcode)
          OP_SETN: begin
            regWrite = 1'b1;
            wdSel    = WD_IMM;
          end
          OP_ADD, OP_SUB: begin
            regWrite = 1'b1;
          end
          OP_JUMPN: begin
            pcWrite = 1'b1;
            pcSel   = PCSEL_JUMP;
          end
          OP_JEQZN: begin
            pcWrite = zero;
            pcSel   = PCSEL_JUMP;
          end
          OP_JNEZN: begin
            pcWrite = !zero;
            pcSel   = PCSEL_JUMP;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        // Request held every MEM cycle; only the ack cycle writes back
        dmemReq = 1'b1;
        dmemWe  = (w_opcode == OP_STORER);
        if (dmemAck) begin
          w_next_state = ST_FETCH;
          w_retire     = 1'b1;
          if (w_opcode == OP_LOADR) begin
            regWrite = 1'b1;
            wdSel    = WD_DMEM;
          end
        end
      end

      ST_HALT: ;

      default: w_next_state = ST_IDLE;
    endcase
  end

  // Instruction-derived outputs are forced low while reset is asserted so
  // that every output reads 0 during reset.
  assign ra1        = reset ? w_ra1 : 2'b00;
  assign ra2        = reset ? w_ra2 : 2'b00;
  assign wa3        = reset ? w_wa3 : 2'b00;
  assign jumpTarget = reset ? w_jump_target : 8'd0;
  assign aluSub     = reset ? w_alu_sub : 1'b0;

  assign halted     = (r_state == ST_HALT);
  assign illegal    = r_illegal;
  assign instrCount = r_count;

endmodule

// File: tb/tb_hmmm_controller.sv
module tb_hmmm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [9:0] instr;
  logic       zero;
  logic       dmemAck;
  logic       imemRead, irWrite, pcWrite, pcSel, regWrite, aluSub;
  logic       dmemReq, dmemWe, halted, illegal;
  logic [7:0] jumpTarget, instrCount;
  logic [1:0] ra1, ra2, wa3, wdSel;

  hmmm_controller dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero),
    .dmemAck(dmemAck), .imemRead(imemRead), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcSel(pcSel), .jumpTarget(jumpTarget),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .regWrite(regWrite), .aluSub(aluSub),
    .wdSel(wdSel), .dmemReq(dmemReq), .dmemWe(dmemWe), .halted(halted),
    .illegal(illegal), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_count;

  // Strobe bundle: imemRead irWrite pcWrite pcSel regWrite aluSub wdSel[1:0] dmemReq dmemWe halted illegal
  wire [11:0] obs_strb = {imemRead, irWrite, pcWrite, pcSel, regWrite, aluSub,
                          wdSel, dmemReq, dmemWe, halted, illegal};
  wire [13:0] obs_addr = {ra1, ra2, wa3, jumpTarget};

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_MEM = 4, PH_HALT = 5;

  // Expected strobes for a given phase of an instruction, from the opcode rules.
  function automatic logic [11:0] exp_strb(int ph, logic [9:0] ins, logic z, logic ack, logic ill);
    int op = int'(ins[9:6]);
    logic im = 0, ir = 0, pw = 0, ps = 0, rw = 0, dr = 0, dw = 0, h = 0, il = 0;
    logic [1:0] wd = 2'b00;
    logic as = (op == 4);
    if (ph == PH_FETCH) begin
      im = 1; ir = 1; pw = 1;
    end else if (ph == PH_EXEC) begin
      if (op == 2) begin rw = 1; wd = 2'b01; end
      if (op == 3 || op == 4) rw = 1;
      if (op == 7) begin pw = 1; ps = 1; end
      if (op == 8) begin pw = z; ps = 1; end
      if (op == 9) begin pw = !z; ps = 1; end
    end else if (ph == PH_MEM) begin
      dr = 1;
      dw = (op == 6);
      if (op == 5 && ack) begin rw = 1; wd = 2'b10; end
    end else if (ph == PH_HALT) begin
      h = 1; il = ill;
    end
    return {im, ir, pw, ps, rw, as, wd, dr, dw, h, il};
  endfunction

  function automatic logic [13:0] exp_addr(logic [9:0] ins);
    int op = int'(ins[9:6]);
    logic [1:0] a1 = (op == 8 || op == 9) ? ins[5:4] : ins[3:2];
    logic [1:0] a2 = (op == 6) ? ins[5:4] : ins[1:0];
    logic [7:0] jt = (op == 7) ? {2'b00, ins[5:0]} : {4'b0000, ins[3:0]};
    return {a1, a2, ins[5:4], jt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction starting from a FETCH cycle; checks every cycle
  // against the phase model and the retired count at the end.
  task automatic exec_instr(input logic [9:0] ins, input logic z, input int ack_at,
                            input bit noise, output int req_cycles);
    int op = int'(ins[9:6]);
    logic [11:0] e;
    req_cycles = 0;
    e = exp_strb(PH_FETCH, instr, zero, 1'b0, 1'b0);
    checks++; if (obs_strb !== e) begin errors++; $display("FAIL fetch strobes: got %b expected %b", obs_strb, e); end
    tick();
    instr = ins; zero = z; dmemAck = noise ? 1'($urandom) : 1'b0;
    #1;
    e = exp_strb(PH_DECODE, ins, z, dmemAck, 1'b0);
    checks++; if (obs_strb !== e) begin errors++; $display("FAIL decode strobes instr=%b: got %b expected %b", ins, obs_strb, e); end
    checks++; if (obs_addr !== exp_addr(ins)) begin errors++; $display("FAIL addresses instr=%b: got %h expected %h", ins, obs_addr, exp_addr(ins)); end
    if (op == 0 || op >= 10) begin
      tick(); dmemAck = 1'b0; #1;
      e = exp_strb(PH_HALT, ins, z, 1'b0, op >= 10);
      checks++; if (obs_strb !== e) begin errors++; $display("FAIL halt strobes instr=%b: got %b expected %b", ins, obs_strb, e); end
    end else begin
      if (op == 5 || op == 6) begin
        tick();
        for (int k = 1; k <= ack_at; k++) begin
          dmemAck = (k == ack_at);
          #1;
          e = exp_strb(PH_MEM, ins, z, dmemAck, 1'b0);
          checks++; if (obs_strb !== e) begin errors++; $display("FAIL mem strobes instr=%b cycle %0d: got %b expected %b", ins, k, obs_strb, e); end
          req_cycles += int'(dmemReq);
          tick();
        end
      end else if (op != 1) begin
        tick();
        dmemAck = noise ? 1'($urandom) : 1'b0;
        #1;
        e = exp_strb(PH_EXEC, ins, z, dmemAck, 1'b0);
        checks++; if (obs_strb !== e) begin errors++; $display("FAIL exec strobes instr=%b zero=%b: got %b expected %b", ins, z, obs_strb, e); end
        tick();
      end else begin
        tick();
      end
      dmemAck = 1'b0;
      exp_count = exp_count + 8'd1;
      #1;
      checks++; if (instrCount !== exp_count) begin errors++; $display("FAIL instrCount after instr=%b: got %0d expected %0d", ins, instrCount, exp_count); end
    end
    $display("instr %b zero=%b ack_at=%0d count=%0d", ins, z, ack_at, instrCount);
  endtask

  task automatic restart();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0; exp_count = 8'd0;
    #1;
    checks++; if (obs_strb !== 12'd0 || instrCount !== 8'd0) begin errors++; $display("FAIL idle after reset: strobes %b count %0d expected 0", obs_strb, instrCount); end
    tick();
    checks++; if (obs_strb !== 12'd0) begin errors++; $display("FAIL idle without run: strobes %b expected 0", obs_strb); end
    run = 1'b1;
    tick();
    run = 1'b0;  // deasserting mid-program must not matter
    #1;
    checks++; if ({imemRead, irWrite, pcWrite, pcSel} !== 4'b1110) begin errors++; $display("FAIL start fetch: got %b expected 1110", {imemRead, irWrite, pcWrite, pcSel}); end
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b1; instr = 10'b0011011011; zero = 1'b1; dmemAck = 1'b1;
    repeat (3) tick();
    checks++; if ({obs_strb, obs_addr, instrCount} !== 34'd0) begin errors++; $display("FAIL reset outputs: got %h expected 0", {obs_strb, obs_addr, instrCount}); end
    dmemAck = 1'b0;
    restart();
    $display("reset/start done");
  endtask

  task automatic test_alu();
    int rc;
    exec_instr(10'b0011011011, 1'b0, 1, 1'b0, rc);
    exec_instr(10'b0100011011, 1'b0, 1, 1'b0, rc);
    checks++; if (instrCount !== 8'd2) begin errors++; $display("FAIL alu count: got %0d expected 2", instrCount); end
    exec_instr(10'b0010101101, 1'b0, 1, 1'b0, rc);
  endtask

  task automatic test_mem();
    int rc;
    exec_instr(10'b0101011000, 1'b0, 3, 1'b0, rc);
    checks++; if (rc !== 3) begin errors++; $display("FAIL loadr request cycles: got %0d expected 3", rc); end
    exec_instr(10'b0110011000, 1'b0, 2, 1'b0, rc);
    checks++; if (rc !== 2) begin errors++; $display("FAIL storer request cycles: got %0d expected 2", rc); end
  endtask

  task automatic test_branch();
    int rc;
    exec_instr(10'b1000001001, 1'b1, 1, 1'b0, rc);
    exec_instr(10'b1000001001, 1'b0, 1, 1'b0, rc);
    exec_instr(10'b1001001001, 1'b0, 1, 1'b0, rc);
    exec_instr(10'b1001001001, 1'b1, 1, 1'b0, rc);
    exec_instr(10'b0111101010, 1'b0, 1, 1'b0, rc);
    checks++; if (jumpTarget !== 8'd42) begin errors++; $display("FAIL jumpn target: got %0d expected 42", jumpTarget); end
  endtask

  task automatic test_random();
    int rc;
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op = 4'($urandom_range(1, 9));
      logic [5:0] fld = 6'($urandom);
      exec_instr({op, fld}, 1'($urandom), $urandom_range(1, 4), 1'b1, rc);
    end
  endtask

  task automatic test_reset_mid_mem();
    tick();
    instr = 10'b0101011000; dmemAck = 1'b0;
    #1;
    tick();
    checks++; if (dmemReq !== 1'b1) begin errors++; $display("FAIL mem request before reset: got %b expected 1", dmemReq); end
    reset = 1'b0;
    #1;
    checks++; if ({obs_strb, obs_addr, instrCount} !== 34'd0) begin errors++; $display("FAIL outputs on reset mid-mem: got %h expected 0", {obs_strb, obs_addr, instrCount}); end
    restart();
    $display("reset mid-mem done");
  endtask

  task automatic test_wrap();
    int rc;
    for (int n = 0; n < 256; n++) exec_instr(10'b0001000000, 1'b0, 1, 1'b0, rc);
    checks++; if (instrCount !== 8'd0) begin errors++; $display("FAIL wrap: got %0d expected 0", instrCount); end
  endtask

  task automatic test_halt();
    int rc;
    logic [7:0] held;
    exec_instr(10'b1111000000, 1'b0, 1, 1'b0, rc);
    held = exp_count;
    for (int n = 0; n < 4; n++) begin
      run = ~run;
      tick();
      checks++; if (obs_strb !== exp_strb(PH_HALT, instr, zero, 1'b0, 1'b1) || instrCount !== held) begin
        errors++; $display("FAIL sticky illegal halt: strobes %b count %0d", obs_strb, instrCount);
      end
    end
    run = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (illegal !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset clears halt: halted %b illegal %b expected 0", halted, illegal); end
    restart();
    exec_instr(10'b0000000000, 1'b0, 1, 1'b0, rc);
    checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL halt opcode: halted %b illegal %b expected 1 0", halted, illegal); end
  endtask

  initial begin
    exp_count = 8'd0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_random();
    test_reset_mid_mem();
    test_wrap();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
